mtpsa_user_arbiter: RTL and testbench

MTPSA_USER_ARBITER -- requirements
Module: mtpsa_user_arbiter

---
 rtl/mtpsa_user_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mtpsa_user_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtpsa_user_arbiter.sv
// mtpsa_user_arbiter
// Merges NUM_USERS AXI-Stream user-pipeline outputs into one stream.
// Arbitration is packet-granular round-robin with a per-user enable mask.
// A granted packet runs to its tlast beat without interleaving.
// Each user has a 32-bit forwarded-packet counter.
//
// Handshake rule on every AXI-Stream port: a beat moves on a rising clock
// edge where tvalid and tready are both 1. A source never waits on tready
// before raising tvalid. The arbiter's s_axis_tready depends only on the
// grant and on m_axis_tready, never on s_axis_tvalid.
module mtpsa_user_arbiter #(
  parameter int NUM_USERS          = 4,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 296
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_rst,
  // per-user input streams, user i in slice i
  input  logic [NUM_USERS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_USERS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_USERS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_USERS-1:0]                      s_axis_tvalid,
  input  logic [NUM_USERS-1:0]                      s_axis_tlast,
  output logic [NUM_USERS-1:0]                      s_axis_tready,
  // merged output stream
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic [2:0]                                m_user_id,
  // control and statistics
  input  logic [NUM_USERS-1:0]                      user_enable,
  input  logic                                      cnt_clear,
  output logic [NUM_USERS*32-1:0]                   pkt_count,
  // debug view of the FSM: 0 = IDLE, 1 = PKT
  output logic                                      dbg_state_o
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int GW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam logic [GW:0] NU = (GW+1)'(NUM_USERS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  state_e        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_ptr_q;

  // Unpacked per-user views of the flattened input buses.
  logic [DW-1:0] tdata_a [NUM_USERS];
  logic [KW-1:0] tkeep_a [NUM_USERS];
  logic [UW-1:0] tuser_a [NUM_USERS];

  logic [NUM_USERS-1:0] req;
  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic                 beat_fire;
  logic                 last_fire;

  // (base + off) mod NUM_USERS. Both operands are below NUM_USERS, so one
  // conditional subtraction is enough.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base,
                                             input logic [GW:0]   off);
    logic [GW:0] s;
    s = {1'b0, base} + off;
    if (s >= NU) s = s - NU;
    return s[GW-1:0];
  endfunction

  for (genvar i = 0; i < NUM_USERS; i++) begin : g_slice
    assign tdata_a[i] = s_axis_tdata[i*DW +: DW];
    assign tkeep_a[i] = s_axis_tkeep[i*KW +: KW];
    assign tuser_a[i] = s_axis_tuser[i*UW +: UW];
  end

  // The enable mask only matters here, so it is sampled only in IDLE.
  assign req = s_axis_tvalid & user_enable;

  // Round-robin pick: the first requester found scanning upward from rr_ptr.
  always_comb begin
    logic [GW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_USERS; k++) begin
      cand = wrap_add(rr_ptr_q, (GW+1)'(k));
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign beat_fire = (state_q == ST_PKT) && m_axis_tvalid && m_axis_tready;
  assign last_fire = beat_fire && m_axis_tlast;

  // Arbitration FSM. The grant is held for the whole packet. rr_ptr moves
  // past the owner only when its tlast beat is accepted.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (last_fire) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= wrap_add(grant_q, (GW+1)'(1));
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output mux: in PKT this is a straight copy of the granted user's
  // slice. In IDLE the bus is held at zero.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state_q == ST_PKT) begin
      m_axis_tdata  = tdata_a[grant_q];
      m_axis_tkeep  = tkeep_a[grant_q];
      m_axis_tuser  = tuser_a[grant_q];
      m_axis_tvalid = s_axis_tvalid[grant_q];
      m_axis_tlast  = s_axis_tlast[grant_q];
    end
  end

  assign m_user_id   = 3'(grant_q);
  assign dbg_state_o = (state_q == ST_PKT);

  for (genvar i = 0; i < NUM_USERS; i++) begin : g_user
    logic        hit;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Only the owner sees backpressure. Every other user is held off.
    assign s_axis_tready[i] = (state_q == ST_PKT) && (grant_q == GW'(i)) &&
                              m_axis_tready;

    assign hit = last_fire && (grant_q == GW'(i));

    // Next counter value. A clear that lands on this user's tlast leaves
    // that packet counted, so the counter restarts at 1.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clear) cnt_d = '0;
      if (hit)       cnt_d = cnt_clear ? 32'd1 : cnt_q + 32'd1;
    end

    // Counter register, loaded every cycle. It wraps naturally at 2^32.
    always_ff @(posedge axis_aclk) begin
      if (axis_rst) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign pkt_count[i*32 +: 32] = cnt_q;
  end

endmodule

// File: tb/tb_mtpsa_user_arbiter.sv
// Testbench for mtpsa_user_arbiter: directed packet scenarios checked
// against a packet-level round-robin model and a beat scoreboard.
module tb_mtpsa_user_arbiter;

  localparam int NU = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 16;

  typedef struct packed {
    logic [2:0]    uid;
    logic          last;
    logic [UW-1:0] tuser;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  localparam int BW = $bits(beat_t);

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst;
  logic [NU*DW-1:0]  s_tdata;
  logic [NU*KW-1:0]  s_tkeep;
  logic [NU*UW-1:0]  s_tuser;
  logic [NU-1:0]     s_tvalid;
  logic [NU-1:0]     s_tlast;
  logic [NU-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [2:0]        m_user_id;
  logic [NU-1:0]     user_enable;
  logic              cnt_clear;
  logic [NU*32-1:0]  pkt_count;
  logic              dbg_state;

  mtpsa_user_arbiter #(
    .NUM_USERS(NU), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .axis_aclk(clk), .axis_rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .m_user_id(m_user_id), .user_enable(user_enable), .cnt_clear(cnt_clear),
    .pkt_count(pkt_count), .dbg_state_o(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bench state ----------------
  beat_t            src_q [NU][$];   // beats each source still has to send
  beat_t            pkt_m [NU][$];   // packets loaded but not yet arbitrated
  logic [BW-1:0]    exp_q [$];       // expected output beats, in order
  logic [NU-1:0]    pend_m;
  int               rr_m;
  int               order_q [$];
  logic [31:0]      cnt_m [NU];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               hs_cnt = 0;
  bit               tog = 0;
  bit               sat_chk = 0;
  logic [NU-1:0]    drv_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_srcs();
    beat_t b;
    for (int u = 0; u < NU; u++) begin
      if (src_q[u].size() > 0) begin
        b = src_q[u][0];
        s_tvalid[u]           = 1'b1;
        s_tdata[u*DW +: DW]   = b.data;
        s_tkeep[u*KW +: KW]   = b.keep;
        s_tuser[u*UW +: UW]   = b.tuser;
        s_tlast[u]            = b.last;
      end else begin
        s_tvalid[u] = 1'b0;
        s_tlast[u]  = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int u, input int n, input int tag);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.uid   = 3'(u);
      b.last  = (i == n - 1);
      b.data  = {4'hA, 4'(u), 8'(tag), 16'(i)};
      b.tuser = {4'(u), 4'(tag), 8'(i)};
      b.keep  = b.last ? 4'b0011 : 4'b1111;
      src_q[u].push_back(b);
      pkt_m[u].push_back(b);
    end
    pend_m[u] = 1'b1;
    drive_srcs();
  endtask

  // Packet-level model: all loaded packets compete together; the winner is
  // the first enabled user at or after rr_m, which then moves past it.
  task automatic plan(input logic [NU-1:0] mask);
    int pick;
    order_q.delete();
    pick = 0;
    while (pick >= 0) begin
      pick = -1;
      for (int k = 0; k < NU; k++) begin
        int u;
        u = (rr_m + k) % NU;
        if (pick < 0 && pend_m[u] && mask[u]) pick = u;
      end
      if (pick >= 0) begin
        foreach (pkt_m[pick][j]) exp_q.push_back(pkt_m[pick][j]);
        pkt_m[pick].delete();
        pend_m[pick] = 1'b0;
        rr_m = (pick + 1) % NU;
        order_q.push_back(pick);
      end
    end
  endtask

  // Sources pop a beat after every accepted handshake; optional tready toggle.
  initial begin
    forever begin
      @(negedge clk);
      drv_hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++)
        if (drv_hs[u] && src_q[u].size() > 0) src_q[u].delete(0);
      if (tog) m_tready = ~m_tready;
      drive_srcs();
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    beat_t       e;
    logic [2:0]  own;
    logic [NU-1:0] exp_rdy;
    bit          after_last;
    int          gap;
    after_last = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        after_last = 0;
      end else begin
        for (int u = 0; u < NU; u++)
          chk("pkt_count", 64'(pkt_count[u*32 +: 32]), 64'(cnt_m[u]));
        own = '0;
        if (exp_q.size() > 0) begin
          e   = beat_t'(exp_q[0]);
          own = e.uid;
        end
        exp_rdy = '0;
        if (m_tvalid && exp_q.size() > 0 && m_tready) exp_rdy[own] = 1'b1;
        chk("s_tready", 64'(s_tready), 64'(exp_rdy));
        if (cnt_clear)
          for (int u = 0; u < NU; u++) cnt_m[u] = '0;
        if (m_tvalid) begin
          if (after_last) begin
            if (sat_chk) chk("idle_gap", 64'(gap), 64'd1);
            after_last = 0;
          end
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 64'(m_tvalid), 64'd0);
          end else begin
            chk("m_user_id", 64'(m_user_id), 64'(own));
            if (m_tready) begin
              e = beat_t'(exp_q.pop_front());
              hs_cnt++;
              chk("tdata", 64'(m_tdata), 64'(e.data));
              chk("tkeep", 64'(m_tkeep), 64'(e.keep));
              chk("tuser", 64'(m_tuser), 64'(e.tuser));
              chk("tlast", 64'(m_tlast), 64'(e.last));
              if (e.last) begin
                cnt_m[own] = cnt_m[own] + 32'd1;
                after_last = 1;
                gap = 0;
              end
            end
          end
        end else if (after_last) begin
          gap++;
        end
      end
    end
  end

  task automatic wait_exp(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    if (exp_q.size() > 0) fail_bound(name);
    step();
    step();
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3);
    @(negedge clk);
    chk(name, 64'(pkt_count[31:0]),   64'(c0));
    chk(name, 64'(pkt_count[63:32]),  64'(c1));
    chk(name, 64'(pkt_count[95:64]),  64'(c2));
    chk(name, 64'(pkt_count[127:96]), 64'(c3));
  endtask

  // Waits, at negedges, until the given user shows a beat on the output.
  task automatic wait_beat(input string name, input int u, input bit need_hs);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(m_tvalid && m_user_id == 3'(u) && (!need_hs || m_tready)) && c < 100);
    if (c >= 100) fail_bound(name);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int h0;
    rst = 1'b1;
    m_tready = 1'b1;
    user_enable = 4'b1111;
    cnt_clear = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0;
    pend_m = '0;
    rr_m = 0;
    for (int u = 0; u < NU; u++) cnt_m[u] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_user_id", 64'(m_user_id), 64'd0);
    chk("rst_cnt_lo", pkt_count[63:0], 64'd0);
    chk("rst_cnt_hi", pkt_count[127:64], 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    step();

    // Four simultaneous 3-beat packets -> order 0,1,2,3
    sat_chk = 1;
    for (int u = 0; u < NU; u++) load_pkt(u, 3, 1);
    plan(4'b1111);
    chk("order_all", 64'((order_q[0] << 12) | (order_q[1] << 8) | (order_q[2] << 4) | order_q[3]),
        64'h0123);
    @(negedge clk);
    chk("grant_cycle_idle", 64'(m_tvalid), 64'd0);
    step();
    @(negedge clk);
    chk("first_beat_valid", 64'(m_tvalid), 64'd1);
    chk("first_beat_user", 64'(m_user_id), 64'd0);
    wait_exp("drain_all4", 200);
    sat_chk = 0;
    chk_cnt("cnt_after_all4", 32'd1, 32'd1, 32'd1, 32'd1);

    // User 2 alone, 5 beats, m_tready toggling
    step();
    load_pkt(2, 5, 2);
    plan(4'b1111);
    chk("order_u2", 64'(order_q.size()), 64'd1);
    chk("order_u2_id", 64'(order_q[0]), 64'd2);
    h0 = hs_cnt;
    tog = 1;
    wait_exp("drain_toggle", 200);
    tog = 0;
    m_tready = 1'b1;
    chk("toggle_beats", 64'(hs_cnt - h0), 64'd5);
    chk_cnt("cnt_after_toggle", 32'd1, 32'd1, 32'd2, 32'd1);

    // Mask 1011: user 2 held off; user 0 disabled mid-packet still completes
    step();
    user_enable = 4'b1011;
    load_pkt(0, 4, 3);
    load_pkt(1, 2, 3);
    load_pkt(2, 2, 3);
    load_pkt(3, 2, 3);
    plan(4'b1011);
    chk("order_masked", 64'((order_q[0] << 8) | (order_q[1] << 4) | order_q[2]), 64'h301);
    wait_beat("wait_u0", 0, 0);
    @(posedge clk); #2;
    user_enable = 4'b1010;
    wait_exp("drain_masked", 300);
    repeat (8) step();
    @(negedge clk);
    chk("u2_still_valid", 64'(s_tvalid[2]), 64'd1);
    chk("u2_blocked", 64'(s_tready[2]), 64'd0);
    chk("idle_masked", 64'(m_tvalid), 64'd0);
    @(posedge clk); #2;
    user_enable = 4'b1111;
    plan(4'b1111);
    chk("order_u2_late", 64'(order_q[0]), 64'd2);
    wait_exp("drain_u2_late", 200);
    chk_cnt("cnt_after_mask", 32'd2, 32'd2, 32'd3, 32'd2);

    // Counter wrap and clear coinciding with tlast
    step();
    force dut.g_user[1].cnt_q = 32'hFFFF_FFFF;
    cnt_m[1] = 32'hFFFF_FFFF;
    step();
    release dut.g_user[1].cnt_q;
    @(negedge clk);
    chk("cnt_preload", 64'(pkt_count[63:32]), 64'hFFFF_FFFF);
    @(posedge clk); #2;
    load_pkt(1, 1, 4);
    plan(4'b1111);
    wait_exp("drain_wrap", 200);
    @(negedge clk);
    chk("cnt_wrap", 64'(pkt_count[63:32]), 64'd0);
    @(posedge clk); #2;
    load_pkt(1, 2, 5);
    plan(4'b1111);
    wait_beat("wait_u1_first", 1, 1);
    @(posedge clk); #2;
    cnt_clear = 1'b1;
    @(posedge clk); #2;
    cnt_clear = 1'b0;
    wait_exp("drain_clear", 200);
    chk_cnt("cnt_clear_tlast", 32'd0, 32'd1, 32'd0, 32'd0);

    // Reset on beat 2 of a 4-beat packet from user 3
    step();
    load_pkt(3, 4, 6);
    plan(4'b1111);
    wait_beat("wait_u3_first", 3, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      src_q[u].delete();
      pkt_m[u].delete();
      cnt_m[u] = '0;
    end
    exp_q.delete();
    pend_m = '0;
    rr_m = 0;
    drive_srcs();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_cnt_lo", pkt_count[63:0], 64'd0);
    chk("rst_mid_cnt_hi", pkt_count[127:64], 64'd0);
    chk("rst_mid_user_id", 64'(m_user_id), 64'd0);
    @(posedge clk); #2;
    load_pkt(0, 2, 7);
    load_pkt(3, 2, 7);
    plan(4'b1111);
    chk("order_after_rst", 64'((order_q[0] << 4) | order_q[1]), 64'h03);
    wait_exp("drain_after_rst", 200);
    chk_cnt("cnt_after_rst", 32'd1, 32'd0, 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
